// File: rtl/el2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : el2_pkg
//  Brief    : Shared types and constants for the EL2 LSU store buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package el2_pkg;

    // Entry address is kept at full width so the struct is independent of the
    // top-level ADDR_W; only the low ADDR_W bits are ever non-zero.
    localparam int C_STBUF_ADDR_MAX_W = 32;

    typedef struct packed {
        logic                          valid;
        logic [C_STBUF_ADDR_MAX_W-1:0] addr;
        logic [31:0]                   data;
        logic [3:0]                    byteen;
    } el2_stbuf_entry_t;

endpackage
`default_nettype wire

// File: rtl/el2_lsu_stbuf_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : el2_lsu_stbuf_fwd
//  Brief    : Combinational store-to-load forwarding merge. For every byte
//             lane the youngest valid entry matching the load word address
//             and enabling that lane supplies the byte.
//  Revision : 1.0 - initial release
// ============================================================================
module el2_lsu_stbuf_fwd
    import el2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  el2_stbuf_entry_t  entries [DEPTH],
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [31:0]       ld_addr,
    output logic [3:0]        fwd_byteen,
    output logic [31:0]       fwd_data
);

    logic [IDX_W-1:0] w_idx;

    // Walk entries oldest to youngest from the read pointer so later hits overwrite earlier ones.
    always_comb begin
        fwd_byteen = 4'h0;
        fwd_data   = 32'h0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = rd_idx + IDX_W'(k);
            if (entries[w_idx].valid &&
                ((entries[w_idx].addr & ~32'h3) == (ld_addr & ~32'h3))) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries[w_idx].byteen[b]) begin
                        fwd_byteen[b]      = 1'b1;
                        fwd_data[8*b +: 8] = entries[w_idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/el2_lsu_stbuf_q.sv
`default_nettype none
// ============================================================================
//  Module   : el2_lsu_stbuf_q
//  Brief    : In-order store-buffer queue. Accepts committed stores from R,
//             presents the oldest to the DCCM write port, and forwards
//             pending store bytes to loads in M.
//  Revision : 1.0 - initial release
// ============================================================================
module el2_lsu_stbuf_q
    import el2_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ldst_stbuf_reqvld_r,
    input  logic                      lsu_flush_r,
    input  logic [ADDR_W-1:0]         store_addr_r,
    input  logic [31:0]               store_data_r,
    input  logic [3:0]                store_byteen_r,
    output logic                      stbuf_reqvld_any,
    output logic [ADDR_W-1:0]         stbuf_addr_any,
    output logic [31:0]               stbuf_data_any,
    output logic [3:0]                stbuf_byteen_any,
    input  logic                      stbuf_ack_any,
    output logic                      stbuf_reqvld_flushed_any,
    output logic                      lsu_stbuf_empty_any,
    output logic                      lsu_stbuf_full_any,
    output logic [$clog2(DEPTH):0]    stbuf_count,
    output logic                      stbuf_overflow_err,
    input  logic [ADDR_W-1:0]         ld_addr_m,
    output logic [3:0]                ld_fwd_byteen_m,
    output logic [31:0]               ld_fwd_data_m
);

    localparam int C_IDX_W = $clog2(DEPTH);
    localparam int C_PTR_W = C_IDX_W + 1;

    el2_stbuf_entry_t   r_entries [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic               r_overflow;

    logic [C_IDX_W-1:0] w_wr_idx;
    logic [C_IDX_W-1:0] w_rd_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_alloc;
    logic               w_pop;
    el2_stbuf_entry_t   w_head;

    assign w_wr_idx = r_wr_ptr[C_IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[C_IDX_W-1:0];

    // Full is taken from registered pointers only: an ack this cycle does not free a slot until next cycle.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[C_PTR_W-1] != r_rd_ptr[C_PTR_W-1]);
    assign w_alloc = ldst_stbuf_reqvld_r & ~lsu_flush_r & ~w_full;
    assign w_pop   = stbuf_ack_any & ~w_empty;
    assign w_head  = r_entries[w_rd_idx];

    assign stbuf_reqvld_any         = ~w_empty;
    assign stbuf_addr_any           = w_head.addr[ADDR_W-1:0];
    assign stbuf_data_any           = w_head.data;
    assign stbuf_byteen_any         = w_head.byteen;
    assign stbuf_reqvld_flushed_any = ldst_stbuf_reqvld_r & lsu_flush_r;
    assign lsu_stbuf_empty_any      = w_empty;
    assign lsu_stbuf_full_any       = w_full;
    assign stbuf_count              = r_wr_ptr - r_rd_ptr;
    assign stbuf_overflow_err       = r_overflow;

    // Entry storage, pointers and the sticky overflow flag; reset discards pending stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_entries[w_wr_idx].valid  <= 1'b1;
                r_entries[w_wr_idx].addr   <= C_STBUF_ADDR_MAX_W'(store_addr_r);
                r_entries[w_wr_idx].data   <= store_data_r;
                r_entries[w_wr_idx].byteen <= store_byteen_r;
                r_wr_ptr                   <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_entries[w_rd_idx].valid <= 1'b0;
                r_rd_ptr                  <= r_rd_ptr + C_PTR_W'(1);
            end
            if (ldst_stbuf_reqvld_r & ~lsu_flush_r & w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    el2_lsu_stbuf_fwd #(
        .DEPTH (DEPTH),
        .IDX_W (C_IDX_W)
    ) u_fwd (
        .entries    (r_entries),
        .rd_idx     (w_rd_idx),
        .ld_addr    (32'(ld_addr_m)),
        .fwd_byteen (ld_fwd_byteen_m),
        .fwd_data   (ld_fwd_data_m)
    );

endmodule
`default_nettype wire

// File: tb/tb_el2_lsu_stbuf_q.sv
`default_nettype none
// ============================================================================
//  Module   : tb_el2_lsu_stbuf_q
//  Brief    : Randomized self-checking bench for el2_lsu_stbuf_q with a
//             queue-based reference model and a negedge monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_el2_lsu_stbuf_q;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req = 1'b0;
    logic            fl  = 1'b0;
    logic [AW-1:0]   st_addr = '0;
    logic [31:0]     st_data = '0;
    logic [3:0]      st_be   = '0;
    logic            ack = 1'b0;
    logic [AW-1:0]   ld_addr = '0;

    logic            reqvld, flushed, empty, full, ovf;
    logic [AW-1:0]   hd_addr;
    logic [31:0]     hd_data, fwd_data;
    logic [3:0]      hd_be, fwd_be;
    logic [CW-1:0]   count;

    el2_lsu_stbuf_q #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .ldst_stbuf_reqvld_r      (req),
        .lsu_flush_r              (fl),
        .store_addr_r             (st_addr),
        .store_data_r             (st_data),
        .store_byteen_r           (st_be),
        .stbuf_reqvld_any         (reqvld),
        .stbuf_addr_any           (hd_addr),
        .stbuf_data_any           (hd_data),
        .stbuf_byteen_any         (hd_be),
        .stbuf_ack_any            (ack),
        .stbuf_reqvld_flushed_any (flushed),
        .lsu_stbuf_empty_any      (empty),
        .lsu_stbuf_full_any       (full),
        .stbuf_count              (count),
        .stbuf_overflow_err       (ovf),
        .ld_addr_m                (ld_addr),
        .ld_fwd_byteen_m          (fwd_be),
        .ld_fwd_data_m            (fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
    } ent_t;

    // Reference model: pending stores in program order, sticky overflow, and
    // whether storage is still in its post-reset cleared state.
    ent_t m_q[$];
    bit   m_ovf   = 1'b0;
    bit   m_clean = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every status, head and forwarding output against the model mid-cycle.
    always @(negedge clk) begin
        logic [3:0]  ebe;
        logic [31:0] ed;
        if (!rst) begin
            chk("count",   32'(count),   32'(m_q.size()));
            chk("empty",   32'(empty),   32'(m_q.size() == 0));
            chk("full",    32'(full),    32'(m_q.size() == DEPTH));
            chk("reqvld",  32'(reqvld),  32'(m_q.size() != 0));
            chk("ovf",     32'(ovf),     32'(m_ovf));
            chk("flushed", 32'(flushed), 32'(req & fl));
            if (reqvld) begin
                if (m_q.size() == 0) begin
                    chk("head_unexpected", 32'(reqvld), 32'h0);
                end else begin
                    chk("head_addr", 32'(hd_addr), 32'(m_q[0].a));
                    chk("head_data", hd_data,      m_q[0].d);
                    chk("head_be",   32'(hd_be),   32'(m_q[0].be));
                end
            end else if (m_clean) begin
                chk("head_clr", {hd_data[31:4], hd_be} ^ 32'(hd_addr), 32'h0);
            end
            ebe = 4'h0;
            ed  = 32'h0;
            foreach (m_q[i]) begin
                if (m_q[i].a[AW-1:2] == ld_addr[AW-1:2]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_q[i].be[b]) begin
                            ebe[b]      = 1'b1;
                            ed[8*b +: 8] = m_q[i].d[8*b +: 8];
                        end
                    end
                end
            end
            chk("fwd_be",   32'(fwd_be), 32'(ebe));
            chk("fwd_data", fwd_data,    ed);
        end
    end

    // One clock of stimulus; the model advances at the same edge as the DUT.
    task automatic step(input bit r, input bit f, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit k, input logic [AW-1:0] ld);
        bit was_full;
        req = r; fl = f; st_addr = a; st_data = d; st_be = be; ack = k; ld_addr = ld;
        @(posedge clk);
        was_full = (m_q.size() == DEPTH);
        if (r && !f && was_full) m_ovf = 1'b1;
        if (k && m_q.size() > 0) void'(m_q.pop_front());
        if (r && !f && !was_full) begin
            m_q.push_back('{a: a, d: d, be: be});
            m_clean = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input bit k);
        step(1'b0, 1'b0, '0, '0, '0, k, ld_addr);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; fl = 1'b0; ack = 1'b0;
        @(posedge clk);
        m_q.delete();
        m_ovf   = 1'b0;
        m_clean = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        idle(1'b0);

        // Single allocation, held without ack.
        step(1'b1, 1'b0, 16'h0100, 32'hAABBCCDD, 4'hF, 1'b0, 16'h0000);
        chk("alloc_reqvld", 32'(reqvld), 32'h1);
        chk("alloc_addr",   32'(hd_addr), 32'h0100);
        chk("alloc_data",   hd_data, 32'hAABBCCDD);
        chk("alloc_count",  32'(count), 32'h1);
        idle(1'b0);

        // Fill, then overflow.
        for (int i = 1; i < DEPTH; i++)
            step(1'b1, 1'b0, 16'(16'h0100 + 4*i), 32'(i), 4'hF, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0F00, 32'hDEAD, 4'hF, 1'b0, 16'h0000);
        chk("ovf_set",    32'(ovf),   32'h1);
        chk("ovf_count",  32'(count), 32'h4);
        idle(1'b0);

        // Alloc+ack at full: pop only. Then at count 2: count unchanged.
        step(1'b1, 1'b0, 16'h0E00, 32'hBEEF, 4'hF, 1'b1, 16'h0000);
        chk("full_ackalloc_count", 32'(count), 32'h3);
        idle(1'b1);
        step(1'b1, 1'b0, 16'h0E04, 32'hCAFE, 4'h3, 1'b1, 16'h0000);
        chk("mid_ackalloc_count", 32'(count), 32'h2);

        // Flushed allocation.
        step(1'b1, 1'b1, 16'h0D00, 32'h1234, 4'hF, 1'b0, 16'h0000);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        chk("ovf_sticky", 32'(ovf), 32'h1);

        // Forwarding with younger-wins lane merge.
        step(1'b1, 1'b0, 16'h0200, 32'h00001122, 4'h3, 1'b0, 16'h0200);
        step(1'b1, 1'b0, 16'h0202, 32'h00334400, 4'h6, 1'b0, 16'h0200);
        chk("fwd_spec_be",   32'(fwd_be), 32'h7);
        chk("fwd_spec_data", fwd_data,    32'h00334422);
        idle(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Wrap-around: ten alloc/ack pairs.
        step(1'b1, 1'b0, 16'h0300, 32'h5000, 4'hF, 1'b0, 16'h0300);
        for (int i = 1; i <= 10; i++)
            step(1'b1, 1'b0, 16'(16'h0300 + 4*i), 32'(32'h5000 + i), 4'hF, 1'b1, 16'h0300);
        idle(1'b1);

        // Randomized traffic over a small address window to provoke forwarding hits.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 16'(16'h0400 + $urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1, 16'(16'h0400 + $urandom_range(0, 15)));

        // Reset with entries pending.
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 16'(16'h0600 + 4*i), 32'(i + 7), 4'hF, 1'b0, 16'h0600);
        do_reset();
        chk("rst_empty",  32'(empty),  32'h1);
        chk("rst_count",  32'(count),  32'h0);
        chk("rst_reqvld", 32'(reqvld), 32'h0);
        idle(1'b0);
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
